// File: rtl/hd_bus_xfer.sv
// ============================================================================
// Module   : hd_bus_xfer
// Brief    : Half-duplex strobed pad transactor feeding a tristate IO buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hd_bus_xfer #(
    parameter int DATA_WIDTH = 8,
    parameter int STB_CYCLES = 2,
    parameter int TA_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bus_stb,
    output logic [DATA_WIDTH-1:0] dio_i,
    output logic [DATA_WIDTH-1:0] dio_t,
    input  logic [DATA_WIDTH-1:0] dio_o
);

    generate
        if (STB_CYCLES < 2) begin : g_bad_stb
            $error("hd_bus_xfer: STB_CYCLES must be 2 or more");
        end
        if (TA_CYCLES < 1) begin : g_bad_ta
            $error("hd_bus_xfer: TA_CYCLES must be 1 or more");
        end
    endgenerate

    localparam int CNT_MAX = (STB_CYCLES > TA_CYCLES) ? STB_CYCLES : TA_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] STB_LAST = CW'(STB_CYCLES - 1);
    localparam logic [CW-1:0] TA_LAST  = CW'(TA_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TA    = 3'd1,
        DRIVE = 3'd2,
        READ  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    last_rd;
    logic [DATA_WIDTH-1:0]   in_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_rd   <= 1'b0;
            in_q      <= '0;
            wdata_q   <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            bus_stb   <= 1'b0;
            dio_i     <= '0;
            dio_t     <= '1;
        end else begin
            in_q <= dio_o;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wdata_q   <= cmd_wdata;
                        cnt       <= '0;
                        if (!cmd_wr) begin
                            state   <= READ;
                            bus_stb <= 1'b1;
                        end else if (last_rd) begin
                            state <= TA;
                        end else begin
                            state   <= DRIVE;
                            dio_t   <= '0;
                            dio_i   <= cmd_wdata;
                            bus_stb <= 1'b1;
                        end
                    end
                end
                TA: begin
                    // Bus stays released so the far end can stop driving before we do.
                    if (cnt == TA_LAST) begin
                        state   <= DRIVE;
                        cnt     <= '0;
                        last_rd <= 1'b0;
                        dio_t   <= '0;
                        dio_i   <= wdata_q;
                        bus_stb <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == STB_LAST) begin
                        state     <= RESP;
                        dio_t     <= '1;
                        dio_i     <= '0;
                        bus_stb   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    // in_q here holds the pad value captured one edge earlier.
                    if (cnt == STB_LAST) begin
                        state     <= RESP;
                        bus_stb   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= 1'b0;
                        rsp_rdata <= in_q;
                        last_rd   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    bus_stb   <= 1'b0;
                    dio_i     <= '0;
                    dio_t     <= '1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hd_bus_xfer.sv
// ============================================================================
// Module   : tb_hd_bus_xfer
// Brief    : Directed and randomized self-checking bench for hd_bus_xfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hd_bus_xfer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_wr;
    logic [7:0] rsp_rdata;
    logic       bus_stb;
    logic [7:0] dio_i;
    logic [7:0] dio_t;
    logic [7:0] dio_o;
    logic [7:0] pad_val;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Pad: external device drives pad_val whenever the transactor releases the bus.
    assign dio_o = (dio_t == 8'hFF) ? pad_val : dio_i;

    hd_bus_xfer #(.DATA_WIDTH(8), .STB_CYCLES(2), .TA_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .bus_stb(bus_stb), .dio_i(dio_i), .dio_t(dio_t), .dio_o(dio_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] wd);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_drive(input string tag, input logic [7:0] wd);
        chk({tag, "_t"}, 32'(dio_t), 32'h00);
        chk({tag, "_i"}, 32'(dio_i), 32'(wd));
        chk({tag, "_stb"}, 32'(bus_stb), 32'h1);
    endtask

    task automatic chk_released(input string tag, input logic stb);
        chk({tag, "_t"}, 32'(dio_t), 32'hFF);
        chk({tag, "_stb"}, 32'(bus_stb), 32'(stb));
    endtask

    task automatic chk_resp(input string tag, input logic wr, input logic [7:0] rd);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_wr"}, 32'(rsp_wr), 32'(wr));
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(rd));
        chk({tag, "_t"}, 32'(dio_t), 32'hFF);
    endtask

    initial begin
        logic       r_wr;
        logic [7:0] r_wd;
        logic       bad;
        logic       seen;
        int         wait_n;

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_wdata = 8'h00;
        rsp_ready = 1'b1; pad_val = 8'h00;
        step(); step();
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_t", 32'(dio_t), 32'hFF);
        chk("rst_i", 32'(dio_i), 32'h00);
        chk("rst_stb", 32'(bus_stb), 32'h0);
        chk("rst_rwr", 32'(rsp_wr), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h00);
        rst = 1'b0;
        step();

        // Write 0xA5 with no turnaround
        issue(1'b1, 8'hA5);
        chk_drive("w1_c1", 8'hA5);
        chk("w1_c1_ready", 32'(cmd_ready), 32'h0);
        step();
        chk_drive("w1_c2", 8'hA5);
        chk("w1_c2_valid", 32'(rsp_valid), 32'h0);
        step();
        chk_resp("w1_c3", 1'b1, 8'h00);
        chk("w1_c3_stb", 32'(bus_stb), 32'h0);
        step();
        chk("w1_c4_valid", 32'(rsp_valid), 32'h0);
        chk("w1_c4_ready", 32'(cmd_ready), 32'h1);

        // Read of 0x3C
        pad_val = 8'h3C;
        issue(1'b0, 8'h00);
        chk_released("r1_c1", 1'b1);
        step();
        chk_released("r1_c2", 1'b1);
        chk("r1_c2_valid", 32'(rsp_valid), 32'h0);
        step();
        chk_resp("r1_c3", 1'b0, 8'h3C);
        step();
        chk("r1_c4_ready", 32'(cmd_ready), 32'h1);

        // Write 0x5A after the read: two turnaround cycles first
        issue(1'b1, 8'h5A);
        chk_released("ta_c1", 1'b0);
        chk("ta_c1_i", 32'(dio_i), 32'h00);
        step();
        chk_released("ta_c2", 1'b0);
        step();
        chk_drive("w2_c3", 8'h5A);
        step();
        chk_drive("w2_c4", 8'h5A);
        step();
        chk_resp("w2_c5", 1'b1, 8'h00);
        step();

        // Following write has no turnaround
        issue(1'b1, 8'h33);
        chk_drive("w3_c1", 8'h33);
        step(); step();
        chk_resp("w3_c3", 1'b1, 8'h00);
        step();

        // Backpressure on a read of 0x81
        pad_val = 8'h81;
        rsp_ready = 1'b0;
        issue(1'b0, 8'h00);
        step(); step();
        pad_val = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rdata", 32'(rsp_rdata), 32'h81);
            chk("bp_ready", 32'(cmd_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_end_valid", 32'(rsp_valid), 32'h0);
        chk("bp_end_ready", 32'(cmd_ready), 32'h1);

        // Reset in the second DRIVE cycle (after the TA caused by the read)
        issue(1'b1, 8'h77);
        step(); step(); step();
        chk_drive("rd_pre", 8'h77);
        rst = 1'b1;
        #1;
        chk_released("rd_async", 1'b0);
        chk("rd_async_valid", 32'(rsp_valid), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rd_post_valid", 32'(rsp_valid), 32'h0);
        issue(1'b1, 8'h11);
        chk_drive("rd_w_c1", 8'h11);
        step(); step();
        chk_resp("rd_w_c3", 1'b1, 8'h00);
        step();

        // Read then reset in RESP: last_rd must clear, so the write skips TA
        pad_val = 8'h42;
        rsp_ready = 1'b0;
        issue(1'b0, 8'h00);
        step(); step();
        rst = 1'b1; #1; rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        issue(1'b1, 8'hC3);
        chk_drive("lr_w_c1", 8'hC3);
        step(); step(); step();

        // Randomized commands with bus-legality checker
        rsp_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            pad_val = 8'($urandom);
            r_wr    = 1'($urandom);
            r_wd    = 8'($urandom);
            bad     = 1'b0;
            seen    = 1'b0;
            chk("rnd_ready", 32'(cmd_ready), 32'h1);
            issue(r_wr, r_wd);
            for (int c = 0; c < 50 && !seen; c++) begin
                if (rsp_valid) seen = 1'b1;
                else begin
                    if (dio_t != 8'hFF && !(dio_t == 8'h00 && bus_stb && r_wr)) bad = 1'b1;
                    if (dio_t == 8'h00 && dio_i != r_wd) bad = 1'b1;
                    step();
                end
            end
            chk("rnd_timeout", 32'(seen), 32'h1);
            chk("rnd_bus", 32'(bad), 32'h0);
            chk("rnd_wr", 32'(rsp_wr), 32'(r_wr));
            chk("rnd_rdata", 32'(rsp_rdata), r_wr ? 32'h0 : 32'(pad_val));
            wait_n = int'($urandom_range(0, 2));
            for (int w = 0; w < wait_n; w++) step();
            chk("rnd_hold", 32'(rsp_valid), 32'h1);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("rnd_once", 32'(rsp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
